// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcodes, arbiter FSM states and the latched operand bundle.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'b0000,
    ALU_SRL  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_NOR  = 4'b0111,
    ALU_SLT  = 4'b1010,
    ALU_SLTU = 4'b1011
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } alu_arb_state_t;

  // One port's operation as held in the operand registers
  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    aluop_t      aluop;
  } alu_req_t;

  // Winner among the two requesters: a lone requester wins, a tie goes to
  // the port that did not win last time.
  function automatic logic arb_pick(input logic [1:0] r, input logic last);
    return (r == 2'b11) ? ~last : r[1];
  endfunction

endpackage

// File: rtl/alu_if.sv
// Connection bundle between the arbiter and the shared alu.
interface alu_if;
  import cpu_types_pkg::*;

  logic [31:0] port_a;
  logic [31:0] port_b;
  aluop_t      aluop;
  logic [31:0] out;
  logic        negative;
  logic        overflow;
  logic        zero;

  modport alu  (input port_a, port_b, aluop, output out, negative, overflow, zero);
  modport ctrl (output port_a, port_b, aluop, input out, negative, overflow, zero);
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU. Shifts use op2[4:0]; undefined opcodes yield 0.
module alu
  import cpu_types_pkg::*;
(
  alu_if.alu aif
);

  logic [31:0] a, b, out_c, sum, diff;
  logic        ovf_c;

  assign a    = aif.port_a;
  assign b    = aif.port_b;
  assign sum  = a + b;
  assign diff = a - b;

  // Opcode decode; overflow is only produced by add/sub
  always_comb begin
    out_c = '0;
    ovf_c = 1'b0;
    case (aif.aluop)
      ALU_SLL:  out_c = a << b[4:0];
      ALU_SRL:  out_c = a >> b[4:0];
      ALU_ADD: begin
        out_c = sum;
        ovf_c = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        out_c = diff;
        ovf_c = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_AND:  out_c = a & b;
      ALU_OR:   out_c = a | b;
      ALU_XOR:  out_c = a ^ b;
      ALU_NOR:  out_c = ~(a | b);
      ALU_SLT:  out_c = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: out_c = {31'b0, a < b};
      default:  out_c = '0;
    endcase
  end

  assign aif.out      = out_c;
  assign aif.overflow = ovf_c;
  assign aif.negative = out_c[31];
  assign aif.zero     = (out_c == 32'b0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end sharing one alu: IDLE -> EXEC -> RESP.
// The owner's req is ignored in RESP so it can drop req after seeing done;
// the other port can be granted straight out of RESP.
module alu_arbiter
  import cpu_types_pkg::*;
#(
  parameter logic RR_INIT = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       req,
  input  logic [1:0][31:0] op1,
  input  logic [1:0][31:0] op2,
  input  logic [1:0][3:0]  aluop,
  output logic [1:0]       done,
  output logic [1:0][31:0] res,
  output logic [1:0]       negative,
  output logic [1:0]       overflow,
  output logic [1:0]       zero,
  output logic             busy,
  output logic             gnt
);

  alu_arb_state_t   state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  alu_req_t         opr_q, opr_d;
  logic [1:0]       done_q, done_d;
  logic [1:0][31:0] res_q, res_d;
  logic [1:0]       neg_q, neg_d;
  logic [1:0]       ovf_q, ovf_d;
  logic [1:0]       zero_q, zero_d;

  logic             grant_en, grant_port, other_port;

  alu_if aif ();
  alu u_alu (.aif(aif.alu));

  // The alu only ever sees the latched operands
  assign aif.port_a = opr_q.op1;
  assign aif.port_b = opr_q.op2;
  assign aif.aluop  = opr_q.aluop;

  assign other_port = ~gnt_q;

  // Grant decision: from IDLE by round-robin, from RESP only to the other port
  always_comb begin
    grant_en   = 1'b0;
    grant_port = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        grant_en   = 1'b1;
        grant_port = arb_pick(req, last_q);
      end
      RESP: if (req[other_port]) begin
        grant_en   = 1'b1;
        grant_port = other_port;
      end
      default: ;
    endcase
  end

  // Next-state and next-register values
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    opr_d   = opr_q;
    done_d  = '0;
    res_d   = res_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: if (grant_en) state_d = EXEC;
      EXEC: begin
        res_d[gnt_q]  = aif.out;
        neg_d[gnt_q]  = aif.negative;
        ovf_d[gnt_q]  = aif.overflow;
        zero_d[gnt_q] = aif.zero;
        done_d[gnt_q] = 1'b1;
        state_d       = RESP;
      end
      RESP:    state_d = grant_en ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
    if (grant_en) begin
      gnt_d       = grant_port;
      last_d      = grant_port;
      opr_d.op1   = op1[grant_port];
      opr_d.op2   = op2[grant_port];
      opr_d.aluop = aluop_t'(aluop[grant_port]);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= RR_INIT;
      opr_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      neg_q   <= '0;
      ovf_q   <= '0;
      zero_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      opr_q   <= opr_d;
      done_q  <= done_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign done     = done_q;
  assign res      = res_q;
  assign negative = neg_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign busy     = (state_q != IDLE);
  assign gnt      = gnt_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 RR_INIT, 1'b1, reset value of the last-grant pointer; the default gives port 0 priority on the first tie.

Ports (name, direction, width, meaning):
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 nRST  input  1  reset; synchronous, active-low.
REQ-004 req  input  [1:0]  per-port level request; the port holds its operands stable while req is high.
REQ-005 op1  input  [1:0][31:0]  per-port operand 1.
REQ-006 op2  input  [1:0][31:0]  per-port operand 2.
REQ-007 aluop  input  [1:0] aluop_t (4b)  per-port ALU opcode.
REQ-008 done  output  [1:0]  one-cycle completion pulse for each port.
REQ-009 res  output  [1:0][31:0]  per-port result register, held until that port's next completion.
REQ-010 negative, overflow, zero  output  [1:0] each  per-port flag registers, held like res.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 gnt  output  1  port currently owning the ALU; valid while busy is high.

Function
REQ-013 The block SHALL share one alu instance between two ports using a 3-state FSM: IDLE, EXEC, RESP.
REQ-014 In IDLE with any req bit high, the block SHALL select a winner, latch that port's op1/op2/aluop into operand registers, set gnt to the winner, update last-grant to the winner, and go to EXEC.
REQ-015 If only one req bit is high, that port SHALL win; if both are high, the port not equal to last-grant SHALL win (round-robin).
REQ-016 In IDLE with no request, the FSM SHALL stay in IDLE and all outputs SHALL hold.
REQ-017 The alu SHALL be driven only from the operand registers, never directly from the port inputs.
REQ-018 In EXEC, the block SHALL register the alu result and flags into res[gnt] and the flags[gnt], set done[gnt] for the following cycle, and go to RESP.
REQ-019 The other port's res and flags SHALL be unchanged.
REQ-020 Latency SHALL be 2 cycles from the grant edge to done being visible.
REQ-021 done SHALL be high for exactly one cycle (the RESP cycle) and SHALL be one-hot or zero.
REQ-022 In RESP, req[gnt] SHALL be ignored for that cycle; this one-cycle lockout lets the owner drop req after seeing done.
REQ-023 In RESP, if the other port's req is high, the block SHALL grant that port directly (latch its operands, go to EXEC) without passing through IDLE; otherwise it SHALL go to IDLE.
REQ-024 Sustained throughput SHALL be one operation per 2 cycles when both ports alternate, and one per 3 cycles when a single port streams.
REQ-025 A req that falls before it is granted SHALL be dropped with no done pulse.
REQ-026 A req that falls after the grant SHALL still complete, and done SHALL still pulse.
REQ-027 Arithmetic SHALL be exactly the alu's behaviour; overflow SHALL be meaningful only for ALU_ADD and ALU_SUB.
REQ-028 An undefined opcode SHALL pass through to the alu unchanged, with the result stored as the alu produces it.

Reset
REQ-029 With nRST low at a rising edge, state SHALL become IDLE, done SHALL become 0, res and all flags SHALL become 0, the operand registers and gnt SHALL become 0, and last-grant SHALL become RR_INIT.
REQ-030 A reset asserted in EXEC or RESP SHALL abort the operation: no done pulse and no result write.
REQ-031 The first grant SHALL be possible on the first edge after nRST returns high.

Structure
REQ-032 aluop_t SHALL remain in cpu_types_pkg, with ALU_SLL=0000, SRL=0001, ADD=0010, SUB=0011, AND=0100, OR=0101, XOR=0110, NOR=0111, SLT=1010, SLTU=1011.
REQ-033 The FSM type alu_arb_state_t (IDLE, EXEC, RESP) SHALL be added to cpu_types_pkg.
REQ-034 The only sub-module SHALL be the existing alu, connected through one alu_if instance.
REQ-035 No other hierarchy SHALL be added; next-state logic and register logic SHALL be kept separate.

Verification
REQ-036 Single port: reset, then req[0]=1 with op1=32'h7FFFFFFF, op2=1, ALU_ADD, dropped on done. Required: done[0] exactly 2 cycles after the grant; res[0]=32'h80000000, negative[0]=1, overflow[0]=1, zero[0]=0; done[1] never high.
REQ-037 Tie after reset: req=2'b11, port 0 doing ALU_SUB 5-5, port 1 doing ALU_OR 32'hF0F0_0000|32'h0000_0F0F, both held until their own done. Required: port 0 served first with res[0]=0 and zero[0]=1; port 1 granted in the RESP cycle, its done 2 cycles after port 0's done, res[1]=32'hF0F0_0F0F.
REQ-038 Round-robin fairness: both ports request continuously for 10 operations. Required: grants strictly alternate 0,1,0,1,...; each port completes 5 operations.
REQ-039 Lockout: port 0 keeps req high through done with ALU_SLT of -1 vs 1. Required: res[0]=1; the next grant to port 0 happens no earlier than the cycle after RESP, i.e. through IDLE, one op per 3 cycles.
REQ-040 Reset mid-operation: nRST low during EXEC of ALU_NOR 0,0. Required: no done pulse; res[0]=0; state IDLE; after release, a tie grants port 0.
REQ-041 Withdrawn request: req[1] pulsed for one cycle while port 0 owns the ALU. Required: port 1 is never granted and done[1] stays 0.
